pipelined_decoder_adder: RTL and testbench
==========================================

# pipelined_decoder_adder

Parametrised, pipelined ripple-carry adder built from decoder-style full-adder bit cells. Each bit cell one-hot decodes {a,b,c} into 8 minterms; sum is the OR of minterms 1,2,4,7 and carry is the OR of minterms 3,5,6,7. The WIDTH-bit operation is split into STAGES slices of SLICE bits, with one register stage per slice and a valid/ready handshake on both sides. It is the multi-bit, streaming successor to the single-bit decoder full adder and sits between operand producers and downstream arithmetic consumers.

## Interface
- WIDTH, 8: operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 4: bits added per pipeline stage; must be ≥1.
- STAGES (localparam): WIDTH/SLICE.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract select; present only with ADDER_SUB_EN.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB.

## Operation
- Transfer occurs when valid and ready are both high on a rising edge. A beat is accepted on the input side when in_valid & in_ready.
- Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of A and B using the carry registered by stage k-1. Stage 0 uses cin.
- Each stage registers the following: its valid bit, the partial sum bits computed so far, its carry-out, and the unconsumed upper operand bits.
- Stage ready rule: ready_k = !valid_k | ready_{k+1}, with ready_STAGES = out_ready. Then in_ready = ready_0, which is combinational.
- Bubbles collapse: an empty stage always accepts a beat from the stage before it.
- out_valid is valid_{STAGES-1}. sum and cout come straight from the final-stage registers.
- Result: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- Reset (rst_n low at a clock edge):
  - All valid bits, data registers, sum and cout are cleared to 0.
  - Inputs presented in that cycle are not captured.
  - A reset mid-stream discards every in-flight beat with no partial output.
- While out_valid & !out_ready, sum and cout hold stable. No beat is dropped or duplicated.

## Timing
- Latency: STAGES cycles from the accepting edge to out_valid. With the defaults this is 2 cycles.
- Throughput: one beat per cycle while out_ready is held high.
- Capacity: STAGES beats. When every stage holds a beat and out_ready is low, in_ready is 0.
- Simultaneous accept and emit in the same cycle is legal when full. With out_ready high, a full pipe keeps in_ready at 1.
- Critical path: SLICE chained bit cells plus the ready chain.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists and is captured with each accepted beat.
  - The effective B is b ^ {WIDTH{sub}` }` and the effective carry-in is cin ^ sub.
  - sub=1, cin=0 gives a−b. sub=1, cin=1 gives a−b−1 (borrow-in).
  - For subtraction, cout = NOT borrow.
- ADDER_SUB_EN undefined: the sub port is absent and the block only adds.

## Test plan
WIDTH=8, SLICE=4 throughout.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and a=0x33. Required: out_valid=0, sum=0x00, cout=0, and no output 2 cycles after rst_n rises.
- Cross-slice carry: a=0xFF, b=0x01, cin=0 → exactly 2 cycles later sum=0x00, cout=1. Then a=0x0F, b=0x00, cin=1 → sum=0x10, cout=0.
- Streaming: with out_ready=1, send (0x10,0x20,0), (0x80,0x80,0), (0x7F,0x00,1) on consecutive cycles. Required: 0x30/0, 0x00/1, 0x80/0 on consecutive cycles starting at cycle 2.
- Backpressure: hold out_ready=0 for 4 cycles while in_valid stays high.
  - in_ready falls after 2 beats are accepted.
  - sum stays stable throughout.
  - After release, every beat emerges in order exactly once.
- Mid-stream reset: assert rst_n=0 with 2 beats in flight. Required: next cycle out_valid=0, and neither beat ever appears.
- With ADDER_SUB_EN: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 → sum=0x02, cout=1. Plus 10k random beats with random out_ready, checked against a scoreboard.

Source files
------------

// File: rtl/pipelined_decoder_adder.sv
// pipelined_decoder_adder: streaming ripple-carry adder, one register stage per SLICE-bit slice
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   sub        subtract select (present only when ADDER_SUB_EN is defined)
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result
//   cout       carry-out of the MSB (NOT borrow when subtracting)
//
// Optional feature macro: ADDER_SUB_EN adds the sub port (a - b - cin when sub=1).
module pipelined_decoder_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int STAGES = WIDTH / SLICE;
    // Operand registers exist only between stages; the last stage has no successor.
    localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

    logic [WIDTH-1:0] b0;
    logic             c0;
`ifdef ADDER_SUB_EN
    assign b0 = b ^ {WIDTH{sub}};
    assign c0 = cin ^ sub;
`else
    assign b0 = b;
    assign c0 = cin;
`endif

    logic [STAGES-1:0] v, c, rdy, iv, ic, nc;
    logic [WIDTH-1:0]  ps [STAGES];
    logic [WIDTH-1:0]  ia [STAGES];
    logic [WIDTH-1:0]  ib [STAGES];
    logic [WIDTH-1:0]  isum [STAGES];
    logic [WIDTH-1:0]  nsum [STAGES];
    logic [WIDTH-1:0]  oa [NR];
    logic [WIDTH-1:0]  ob [NR];
    logic              cy;

    // Decoder bit cell: one-hot minterm of {x,y,z}, returns {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        logic [7:0] m;
        m = 8'b1 << {x, y, z};
        return {m[3] | m[5] | m[6] | m[7], m[1] | m[2] | m[4] | m[7]};
    endfunction

    // A stage is ready when it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < STAGES; j++)
                rdy[k] = rdy[k] | ~v[j];
        end
    end

    always_comb begin
        iv = '0;
        ic = '0;
        nc = '0;
        cy = 1'b0;
        ia[0]   = a;
        ib[0]   = b0;
        ic[0]   = c0;
        iv[0]   = in_valid;
        isum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            ia[k]   = oa[k-1];
            ib[k]   = ob[k-1];
            ic[k]   = c[k-1];
            iv[k]   = v[k-1];
            isum[k] = ps[k-1];
        end
        // Operands are shifted down each stage, so every slice adds bits [SLICE-1:0].
        for (int k = 0; k < STAGES; k++) begin
            cy      = ic[k];
            nsum[k] = isum[k];
            for (int i = 0; i < SLICE; i++)
                {cy, nsum[k][k*SLICE+i]} = fa(ia[k][i], ib[k][i], cy);
            nc[k] = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            c <= '0;
            for (int k = 0; k < STAGES; k++)
                ps[k] <= '0;
            for (int k = 0; k < NR; k++) begin
                oa[k] <= '0;
                ob[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= iv[k];
                    if (iv[k]) begin
                        ps[k] <= nsum[k];
                        c[k]  <= nc[k];
                    end
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (rdy[k] && iv[k]) begin
                    oa[k] <= ia[k] >> SLICE;
                    ob[k] <= ib[k] >> SLICE;
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign sum       = ps[STAGES-1];
    assign cout      = c[STAGES-1];
endmodule

// File: tb/tb_pipelined_decoder_adder.sv
// tb_pipelined_decoder_adder: directed and random scoreboard checks of the pipelined adder
module tb_pipelined_decoder_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, cout;
    logic [7:0] sum;

    int         total = 0;
    int         bad = 0;
    int         idx, acc, cyc;
    logic [8:0] q[$];
    logic [8:0] e;
    logic       ir_s;

    always #5 clk = ~clk;

    pipelined_decoder_adder #(.WIDTH(8), .SLICE(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
    );

    function automatic logic [8:0] mdl(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
        return {1'b0, x} + {1'b0, y ^ {8{s}}} + {8'b0, ci ^ s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the scoreboard, then move past the edge.
    task automatic step();
        @(negedge clk);
        ir_s = in_ready;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0)
                chk("sb_unexpected", 32'(q.size()), 1);
            else begin
                e = q.pop_front();
                chk("sb_order", {23'b0, cout, sum}, {23'b0, e});
            end
        end
        if (!rst_n)
            q.delete();
        else if (in_valid && in_ready)
            q.push_back(mdl(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y, input logic ci);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 8'h33;
        step();
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_sum", {24'b0, sum}, 0);
        chk("rst_cout", {31'b0, cout}, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        chk("rst_no_output", {31'b0, out_valid}, 0);

        beat(8'hFF, 8'h01, 1'b0);
        step();
        in_valid = 1'b0;
        chk("carry_not_early", {31'b0, out_valid}, 0);
        step();
        chk("carry_valid", {31'b0, out_valid}, 1);
        chk("carry_res", {23'b0, cout, sum}, 32'h100);
        beat(8'h0F, 8'h00, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("carry2_valid", {31'b0, out_valid}, 1);
        chk("carry2_res", {23'b0, cout, sum}, 32'h010);
        step();

        beat(8'h10, 8'h20, 1'b0);
        step();
        beat(8'h80, 8'h80, 1'b0);
        step();
        chk("stream0_valid", {31'b0, out_valid}, 1);
        chk("stream0_res", {23'b0, cout, sum}, 32'h030);
        beat(8'h7F, 8'h00, 1'b1);
        step();
        chk("stream1_valid", {31'b0, out_valid}, 1);
        chk("stream1_res", {23'b0, cout, sum}, 32'h100);
        in_valid = 1'b0;
        step();
        chk("stream2_valid", {31'b0, out_valid}, 1);
        chk("stream2_res", {23'b0, cout, sum}, 32'h080);
        step();

        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            beat(8'hA0 + 8'(idx), 8'h5F + 8'(idx * 3), 1'(idx));
            step();
            chk("bp_in_ready", {31'b0, ir_s}, (i < 2) ? 1 : 0);
            if (ir_s) idx++;
            if (i >= 1) begin
                chk("bp_valid", {31'b0, out_valid}, 1);
                chk("bp_hold", {23'b0, cout, sum}, {23'b0, mdl(8'hA0, 8'h5F, 1'b0, 1'b0)});
            end
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp_drained", 32'(q.size()), 0);

        out_ready = 1'b0;
        beat(8'h11, 8'h22, 1'b0);
        step();
        beat(8'h33, 8'h44, 1'b1);
        step();
        in_valid = 1'b0;
        chk("mid_inflight", {31'b0, out_valid}, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_output", {31'b0, out_valid}, 0);
        end

`ifdef ADDER_SUB_EN
        sub = 1'b1;
        beat(8'h05, 8'h07, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("sub0_valid", {31'b0, out_valid}, 1);
        chk("sub0_res", {23'b0, cout, sum}, 32'h0FE);
        step();
        beat(8'h07, 8'h05, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("sub1_valid", {31'b0, out_valid}, 1);
        chk("sub1_res", {23'b0, cout, sum}, 32'h102);
        step();
        sub = 1'b0;
`endif

        acc = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            if (!in_valid || ir_s) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
`ifdef ADDER_SUB_EN
                sub = 1'($urandom);
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            if (in_valid && ir_s) acc++;
        end
        chk("rand_count", acc, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rand_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
